// File: rtl/uplink_keyer.sv
// Ground-side uplink bit keyer for the A19 UPL0/UPL1 inputs.
// Characters arrive over a valid/ready handshake into a small FIFO. Each one
// is expanded to the 16-bit triply-redundant word {1, c, ~c, c} and keyed out
// MSB first as timed pulses. UPL1 marks a 1 bit and UPL0 marks a 0 bit.
// BLKUPL holds off new words but never cuts a word short.
module uplink_keyer #(
    parameter int BIT_PERIOD  = 8,
    parameter int PULSE_WIDTH = 2,
    parameter int WORD_GAP    = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4:0]                  char_in,
    input  logic                        char_valid,
    output logic                        char_ready,
    input  logic                        BLKUPL,
    output logic                        UPL0,
    output logic                        UPL1,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (BIT_PERIOD > WORD_GAP) ? BIT_PERIOD : WORD_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // Terminal values of the shared phase counter for each timed state.
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] SPACE_LAST = CNT_W'(BIT_PERIOD - PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(WORD_GAP - 1);
    localparam logic [PTR_W:0]   DEPTH      = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PULSE,
        SPACE,
        GAP
    } state_t;

    // Redundant uplink word: start bit, character, complement, character.
    function automatic logic [15:0] build_word(input logic [4:0] c);
        return {1'b1, c, ~c, c};
    endfunction

    // Control state
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_cnt_nx;
    logic             upl0_nx;
    logic             upl1_nx;

    // FIFO bookkeeping
    logic [4:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Datapath: popped character, then the word being keyed out
    logic [4:0]       char_p0;
    logic [15:0]      word_p1;
    logic [15:0]      word_ld;
    logic             load;
    logic             shift;
    logic             next_bit;

    assign fifo_count = count;
    assign char_ready = (count != DEPTH);
    assign fifo_empty = (count == '0);
    assign push       = char_valid && char_ready;
    assign busy       = (state != IDLE);
    assign word_ld    = build_word(char_p0);

    // Next-state, phase timing, pop/load/shift strobes and next pulse levels.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_cnt_nx = bit_cnt;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        upl0_nx    = 1'b0;
        upl1_nx    = 1'b0;
        next_bit   = word_p1[15];

        case (state)
            IDLE: begin
                if (!fifo_empty && !BLKUPL) begin
                    pop      = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                bit_cnt_nx = '0;
                cnt_nx     = '0;
                state_nx   = PULSE;
            end
            PULSE: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nx   = '0;
                    state_nx = SPACE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            SPACE: begin
                if (cnt == SPACE_LAST) begin
                    cnt_nx     = '0;
                    shift      = 1'b1;
                    bit_cnt_nx = bit_cnt + 1'b1;
                    state_nx   = (bit_cnt == 4'd15) ? GAP : PULSE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nx = '0;
                    if (!fifo_empty && !BLKUPL) begin
                        pop      = 1'b1;
                        state_nx = LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // The pulse registers lead the shift register by one edge, so look
        // at the bit that will be current once this edge has been taken.
        if (state == LOAD) begin
            next_bit = word_ld[15];
        end else if (state == SPACE) begin
            next_bit = word_p1[14];
        end

        if (state_nx == PULSE) begin
            upl1_nx = next_bit;
            upl0_nx = !next_bit;
        end
    end

    // FSM state, phase counters and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            UPL0    <= 1'b0;
            UPL1    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            UPL0    <= upl0_nx;
            UPL1    <= upl1_nx;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Character storage, popped character and word shift register (no reset).
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= char_in;
        end
        if (pop) begin
            char_p0 <= mem[rd_ptr];
        end
        if (load) begin
            word_p1 <= word_ld;
        end else if (shift) begin
            word_p1 <= {word_p1[14:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_uplink_keyer.sv
// Bench for uplink_keyer: expected pulses (bit value, rise cycle) are queued
// when stimulus is issued; a monitor checks every pulse the DUT produces.
module tb_uplink_keyer;

    localparam int PULSE_W = 2;
    localparam int WSPAN   = 145;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] char_in = '0;
    logic       char_valid = 1'b0;
    logic       char_ready;
    logic       BLKUPL = 1'b0;
    logic       UPL0;
    logic       UPL1;
    logic       busy;
    logic [2:0] fifo_count;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic b;
        int   t;
    } exp_t;
    exp_t exp_q[$];

    uplink_keyer dut (
        .clk       (clk),
        .rst       (rst),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .BLKUPL    (BLKUPL),
        .UPL0      (UPL0),
        .UPL1      (UPL1),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Count rising edges; read on the falling edge it equals the last edge number.
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Queue the 16 pulses of one word, first rising at cycle t0.
    task automatic exp_word(input logic [15:0] w, input int t0);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.b = w[15 - i];
            e.t = t0 + 8 * i;
            exp_q.push_back(e);
        end
    endtask

    // Called on a falling edge; returns the number of the handshake edge.
    task automatic push1(input logic [4:0] c, output int k);
        chk("push_ready", char_ready, 1'b1);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (exp_q.size() == 0 && !busy), 1'b1);
    endtask

    task automatic monitor();
        logic hi = 1'b0;
        logic val = 1'b0;
        logic both = 1'b0;
        int   width = 0;
        int   rise_t = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi   = 1'b0;
                both = 1'b0;
            end else if (UPL0 || UPL1) begin
                if (UPL0 && UPL1) both = 1'b1;
                if (!hi) begin
                    hi     = 1'b1;
                    val    = UPL1;
                    width  = 1;
                    rise_t = cyc;
                end else begin
                    width++;
                end
            end else if (hi) begin
                hi = 1'b0;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pulse: got bit=%0d rise=%0d, required no pulse", val, rise_t);
                end else begin
                    e = exp_q.pop_front();
                    if (val !== e.b || width != PULSE_W || rise_t != e.t || both) begin
                        n_bad++;
                        $display("FAIL pulse: got bit=%0d width=%0d rise=%0d both=%0d, required bit=%0d width=%0d rise=%0d both=0",
                                 val, width, rise_t, both, e.b, PULSE_W, e.t);
                    end
                end
                both = 1'b0;
            end
        end
    endtask

    initial begin
        int k;
        int k2;
        int r;
        int l;
        int acc;

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_upl0", UPL0, 1'b0);
        chk("rst_upl1", UPL1, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ready", char_ready, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single character 5'h15
        push1(5'h15, k);
        exp_word(16'hD555, k + 2);
        wait_until(k + 145);
        chk("t1_busy_in_gap", busy, 1'b1);
        @(negedge clk);
        chk("t1_busy_after_gap", busy, 1'b0);
        wait_done("t1_done");

        // 2: back-to-back 5'h00 and 5'h1F
        repeat (3) @(negedge clk);
        push1(5'h00, k);
        push1(5'h1F, k2);
        exp_word(16'h83E0, k + 2);
        exp_word(16'hFC1F, k + 2 + WSPAN);
        wait_done("t2_done");

        // 3: blocked fill, then release; 6: full push meets GAP-end pop
        repeat (3) @(negedge clk);
        BLKUPL = 1'b1;
        acc = 0;
        for (int j = 0; j < 6; j++) begin
            char_in    = 5'(j + 1);
            char_valid = 1'b1;
            if (char_ready) acc++;
            @(negedge clk);
        end
        char_valid = 1'b0;
        chk("t3_accepted", acc, 4);
        chk("t3_ready_low", char_ready, 1'b0);
        chk("t3_count_full", fifo_count, 3'd4);
        repeat (50) @(negedge clk);
        chk("t3_blocked_idle", busy, 1'b0);
        r = cyc;
        BLKUPL = 1'b0;
        exp_word(16'h87C1, r + 2);
        exp_word(16'h8BA2, r + 2 + WSPAN);
        exp_word(16'h8F83, r + 2 + 2 * WSPAN);
        exp_word(16'h9364, r + 2 + 3 * WSPAN);
        exp_word(16'h9745, r + 2 + 4 * WSPAN);
        exp_word(16'hAAAA, r + 2 + 5 * WSPAN);
        wait_until(r + 20);
        char_in    = 5'h05;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        chk("t6_refill", fifo_count, 3'd4);
        wait_until(r + 145);
        char_in    = 5'h0A;
        char_valid = 1'b1;
        chk("t6_ready_low", char_ready, 1'b0);
        chk("t6_count_before", fifo_count, 3'd4);
        @(negedge clk);
        chk("t6_count_popped", fifo_count, 3'd3);
        chk("t6_ready_high", char_ready, 1'b1);
        @(negedge clk);
        char_valid = 1'b0;
        chk("t6_count_pushed", fifo_count, 3'd4);
        wait_done("t3_done");

        // 4: BLKUPL raised during bit 7 with one character queued
        repeat (3) @(negedge clk);
        push1(5'h0A, k);
        push1(5'h15, k2);
        exp_word(16'hAAAA, k + 2);
        wait_until(k + 58);
        BLKUPL = 1'b1;
        wait_until(k + 200);
        chk("t4_word_complete", exp_q.size(), 0);
        chk("t4_held_idle", busy, 1'b0);
        chk("t4_still_queued", fifo_count, 3'd1);
        l = cyc;
        BLKUPL = 1'b0;
        exp_word(16'hD555, l + 2);
        @(negedge clk);
        chk("t4_load_next_edge", busy, 1'b1);
        wait_done("t4_done");

        // 5: reset during the pulse of the fourth bit with 2 characters queued
        repeat (3) @(negedge clk);
        push1(5'h15, k);
        push1(5'h0A, k2);
        push1(5'h1F, k2);
        exp_word(16'hD555, k + 2);
        wait_until(k + 26);
        chk("t5_pulse_high", UPL1, 1'b1);
        chk("t5_queued", fifo_count, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_upl1_drop", UPL1, 1'b0);
        chk("t5_upl0_low", UPL0, 1'b0);
        chk("t5_count_clear", fifo_count, 3'd0);
        chk("t5_busy_clear", busy, 1'b0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("t5_quiet_busy", busy, 1'b0);
        chk("t5_quiet_count", fifo_count, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
